thread_pc_gen: RTL and testbench

Per-thread program-counter generator at the head of the fetch stage. It holds one word-addressed PC per hardware thread and picks a runnable thread round-robin each cycle. It presents the selected thread's PC to instruction fetch through a registered valid/stall interface. It also accepts control-flow redirects: branch/jump targets resolved in execute (`jmp_en`/`jmp_pc`) and exception entry to `HANDLER`. For every redirect it emits a per-thread flush to the downstream pipeline.

---
 rtl/thread_pc_gen_pkg.sv | 20 ++
 rtl/thread_pc_gen_rr_arbiter.sv | 32 +++
 rtl/thread_pc_gen.sv | 184 ++++++++++++++++++
 tb/tb_thread_pc_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/thread_pc_gen_pkg.sv
// Shared types and constants for the per-thread PC generator.
// The exception entry address and thread states are defined here so every unit agrees on them.
package thread_pc_gen_pkg;

    localparam int unsigned DEF_NUM_THREAD = 4;
    localparam int unsigned DEF_TID_W      = $clog2(DEF_NUM_THREAD);
    localparam logic [31:0] HANDLER        = 32'h0000_8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } thread_state_e;

    // Word-addressed PC, wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/thread_pc_gen_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping modulo N.
// N must be a power of two so the W-bit index arithmetic wraps naturally.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_sel,
    output logic         o_any
);

    logic [W-1:0] w_idx;

    always_comb begin
        // NOTE: every variable is given a value before any conditional so no latch is inferred.
        o_sel = '0;
        o_any = 1'b0;
        w_idx = '0;
        // Walk from the farthest offset down so the nearest requester overwrites last.
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = i_ptr + W'(k);
            if (i_req[w_idx]) begin
                o_sel = w_idx;
                o_any = 1'b1;
            end
        end
        o_grant = o_any ? (N'(1) << o_sel) : '0;
    end

endmodule

// File: rtl/thread_pc_gen.sv
// Per-thread PC generator: round-robin fetch selection over RUN threads,
// redirect handling (exception/jump) with one-cycle flush pulses.
module thread_pc_gen
    import thread_pc_gen_pkg::*;
#(
    parameter int unsigned NUM_THREAD = DEF_NUM_THREAD,
    parameter int unsigned TID_W      = $clog2(NUM_THREAD),
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_en,
    input  logic [TID_W-1:0]      start_tid,
    input  logic [31:0]           start_pc,
    input  logic                  kill_en,
    input  logic [TID_W-1:0]      kill_tid,
    input  logic                  jmp_en,
    input  logic [TID_W-1:0]      jmp_tid,
    input  logic [31:0]           jmp_pc,
    input  logic                  exc_en,
    input  logic [TID_W-1:0]      exc_tid,
    input  logic                  stall,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_pc,
    output logic [TID_W-1:0]      fetch_tid,
    output logic                  flush_valid,
    output logic [TID_W-1:0]      flush_tid,
    output logic [NUM_THREAD-1:0] thread_active
);

    thread_state_e          r_state [NUM_THREAD];
    logic [31:0]            r_pc    [NUM_THREAD];
    logic [TID_W-1:0]       r_rr_ptr;
    logic                   r_fetch_valid;
    logic [31:0]            r_fetch_pc;
    logic [TID_W-1:0]       r_fetch_tid;
    logic                   r_flush_valid;
    logic [TID_W-1:0]       r_flush_tid;
    logic                   r_pend_valid;
    logic [TID_W-1:0]       r_pend_tid;

    logic [NUM_THREAD-1:0]  w_active;
    logic [NUM_THREAD-1:0]  w_kill;
    logic [NUM_THREAD-1:0]  w_exc;
    logic [NUM_THREAD-1:0]  w_jmp;
    logic [NUM_THREAD-1:0]  w_start;
    logic [NUM_THREAD-1:0]  w_req;
    logic [NUM_THREAD-1:0]  w_grant;
    logic [TID_W-1:0]       w_sel;
    logic                   w_any;
    logic                   w_load;
    logic                   w_fire;
    logic                   w_exc_any;
    logic                   w_jmp_any;
    logic                   w_held_hit;

    // Per-thread event decode with same-thread priority kill > exc > jmp > start.
    always_comb begin
        w_active = '0;
        w_kill   = '0;
        w_exc    = '0;
        w_jmp    = '0;
        w_start  = '0;
        w_req    = '0;
        for (int i = 0; i < NUM_THREAD; i++) begin
            w_active[i] = (r_state[i] != IDLE);
            w_kill[i]   = kill_en && (kill_tid == TID_W'(i));
            w_exc[i]    = exc_en && (exc_tid == TID_W'(i)) && w_active[i] && !w_kill[i];
            w_jmp[i]    = jmp_en && (jmp_tid == TID_W'(i)) && w_active[i] && !w_kill[i] && !w_exc[i];
            w_start[i]  = start_en && (start_tid == TID_W'(i)) && !w_active[i] && !w_kill[i];
            // Threads redirected or killed this cycle must not be fetched from their stale PC.
            w_req[i]    = (r_state[i] == RUN) && !w_kill[i] && !w_exc[i] && !w_jmp[i];
        end
    end

    rr_arbiter #(
        .N (NUM_THREAD),
        .W (TID_W)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_sel   (w_sel),
        .o_any   (w_any)
    );

    assign w_load     = !r_fetch_valid || !stall;
    assign w_fire     = w_load && w_any;
    assign w_exc_any  = |w_exc;
    assign w_jmp_any  = |w_jmp;
    assign w_held_hit = w_kill[r_fetch_tid] || w_exc[r_fetch_tid] || w_jmp[r_fetch_tid];

    // Thread state and PC array.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the PC array is architectural boot state, so it is reset rather than left undefined.
            for (int i = 0; i < NUM_THREAD; i++) begin
                r_state[i] <= IDLE;
                r_pc[i]    <= '0;
            end
            r_state[0] <= RUN;
            r_pc[0]    <= RESET_PC;
        end else begin
            for (int i = 0; i < NUM_THREAD; i++) begin
                if (w_kill[i]) begin
                    r_state[i] <= IDLE;
                end else if (w_exc[i]) begin
                    r_pc[i]    <= HANDLER;
                    r_state[i] <= HOLD;
                end else if (w_jmp[i]) begin
                    r_pc[i]    <= jmp_pc;
                    r_state[i] <= HOLD;
                end else if (w_start[i]) begin
                    r_pc[i]    <= start_pc;
                    r_state[i] <= RUN;
                end else begin
                    if (r_state[i] == HOLD) begin
                        r_state[i] <= RUN;
                    end
                    if (w_fire && w_grant[i]) begin
                        r_pc[i] <= pc_inc(r_pc[i]);
                    end
                end
            end
        end
    end

    // Fetch request register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= '0;
            r_fetch_tid   <= '0;
            r_rr_ptr      <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_fetch_valid <= 1'b1;
                r_fetch_pc    <= r_pc[w_sel];
                r_fetch_tid   <= w_sel;
                r_rr_ptr      <= w_sel + TID_W'(1);
            end else begin
                r_fetch_valid <= 1'b0;
            end
        end else if (w_held_hit) begin
            // A held request for a redirected or killed thread is stale; withdraw it.
            r_fetch_valid <= 1'b0;
        end
    end

    // Flush pulses: exception first, a simultaneous jump on another thread waits one cycle.
    // With one pending entry, a new exc+jmp pair arriving while an entry waits replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_valid <= 1'b0;
            r_flush_tid   <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_tid    <= '0;
        end else begin
            r_flush_valid <= w_exc_any || w_jmp_any || r_pend_valid;
            if (w_exc_any) begin
                r_flush_tid <= exc_tid;
            end else if (w_jmp_any) begin
                r_flush_tid <= jmp_tid;
            end else if (r_pend_valid) begin
                r_flush_tid <= r_pend_tid;
            end
            if (w_exc_any && w_jmp_any) begin
                r_pend_valid <= 1'b1;
                r_pend_tid   <= jmp_tid;
            end else if (!w_exc_any && !w_jmp_any) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign fetch_valid   = r_fetch_valid;
    assign fetch_pc      = r_fetch_pc;
    assign fetch_tid     = r_fetch_tid;
    assign flush_valid   = r_flush_valid;
    assign flush_tid     = r_flush_tid;
    assign thread_active = w_active;

endmodule

// File: tb/tb_thread_pc_gen.sv
// Directed, table-driven bench for thread_pc_gen (4 threads, RESET_PC=0, HANDLER=0x8000).
module tb_thread_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        start_en;
    logic [1:0]  start_tid;
    logic [31:0] start_pc;
    logic        kill_en;
    logic [1:0]  kill_tid;
    logic        jmp_en;
    logic [1:0]  jmp_tid;
    logic [31:0] jmp_pc;
    logic        exc_en;
    logic [1:0]  exc_tid;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_tid;
    logic        flush_valid;
    logic [1:0]  flush_tid;
    logic [3:0]  thread_active;

    int n_checks = 0;
    int n_fail   = 0;

    thread_pc_gen #(
        .NUM_THREAD (4),
        .TID_W      (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_en      (start_en),
        .start_tid     (start_tid),
        .start_pc      (start_pc),
        .kill_en       (kill_en),
        .kill_tid      (kill_tid),
        .jmp_en        (jmp_en),
        .jmp_tid       (jmp_tid),
        .jmp_pc        (jmp_pc),
        .exc_en        (exc_en),
        .exc_tid       (exc_tid),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_tid     (fetch_tid),
        .flush_valid   (flush_valid),
        .flush_tid     (flush_tid),
        .thread_active (thread_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        st;
        logic [1:0]  stid;
        logic [31:0] spc;
        logic        jm;
        logic [1:0]  jtid;
        logic [31:0] jpc;
        logic        ex;
        logic [1:0]  etid;
        logic        kl;
        logic [1:0]  ktid;
        logic        stl;
        logic        ev;
        logic [1:0]  et;
        logic [31:0] ep;
        logic        fv;
        logic [1:0]  ft;
        logic [3:0]  act;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] base [4] = '{32'h5, 32'h101, 32'h201, 32'h301};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic vec_t seq(input logic [1:0] t, input logic [31:0] p, input logic [3:0] a);
        vec_t v;
        v     = '0;
        v.ev  = 1'b1;
        v.et  = t;
        v.ep  = p;
        v.act = a;
        return v;
    endfunction

    task automatic clear_inputs();
        start_en = 0; start_tid = 0; start_pc = 0;
        kill_en  = 0; kill_tid  = 0;
        jmp_en   = 0; jmp_tid   = 0; jmp_pc = 0;
        exc_en   = 0; exc_tid   = 0;
        stall    = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
        check({tag, "_fetch_pc"}, fetch_pc, 32'd0);
        check({tag, "_fetch_tid"}, 32'(fetch_tid), 32'd0);
        check({tag, "_flush_valid"}, 32'(flush_valid), 32'd0);
        check({tag, "_flush_tid"}, 32'(flush_tid), 32'd0);
        check({tag, "_active"}, 32'(thread_active), 32'h1);
    endtask

    initial begin
        vec_t r;
        string nm;

        // ---- vector table ----
        vecs.push_back(seq(0, 32'h0, 4'h1));
        for (int k = 1; k < 4; k++) vecs.push_back(seq(0, 32'(k), 4'h1));
        r = seq(0, 32'h4, 4'h3);   r.st = 1; r.stid = 1; r.spc = 32'h100; vecs.push_back(r);
        r = seq(1, 32'h100, 4'h7); r.st = 1; r.stid = 2; r.spc = 32'h200; vecs.push_back(r);
        r = seq(2, 32'h200, 4'hF); r.st = 1; r.stid = 3; r.spc = 32'h300; vecs.push_back(r);
        vecs.push_back(seq(3, 32'h300, 4'hF));
        for (int n = 0; n < 18; n++) vecs.push_back(seq(2'(n % 4), base[n % 4] + 32'(n / 4), 4'hF));
        // jump on thread 2 at PC 0x205 during its turn
        r = seq(3, 32'h305, 4'hF); r.jm = 1; r.jtid = 2; r.jpc = 32'h40; r.fv = 1; r.ft = 2; vecs.push_back(r);
        vecs.push_back(seq(0, 32'hA, 4'hF));
        vecs.push_back(seq(1, 32'h106, 4'hF));
        vecs.push_back(seq(2, 32'h40, 4'hF));
        vecs.push_back(seq(3, 32'h306, 4'hF));
        // exception and jump on thread 1 together: exception wins, one flush
        r = seq(0, 32'hB, 4'hF); r.ex = 1; r.etid = 1; r.jm = 1; r.jtid = 1; r.jpc = 32'h80;
        r.fv = 1; r.ft = 1; vecs.push_back(r);
        vecs.push_back(seq(2, 32'h41, 4'hF));
        vecs.push_back(seq(3, 32'h307, 4'hF));
        vecs.push_back(seq(0, 32'hC, 4'hF));
        vecs.push_back(seq(1, 32'h8000, 4'hF));
        vecs.push_back(seq(2, 32'h42, 4'hF));
        vecs.push_back(seq(3, 32'h308, 4'hF));
        // stall holds thread 3's request, then kill withdraws it
        for (int k = 0; k < 3; k++) begin
            r = seq(3, 32'h308, 4'hF); r.stl = 1; vecs.push_back(r);
        end
        r = seq(3, 32'h308, 4'h7); r.stl = 1; r.kl = 1; r.ktid = 3; r.ev = 0; vecs.push_back(r);
        vecs.push_back(seq(0, 32'hD, 4'h7));
        // restart thread 0 at the top of the address space to check wrap
        r = seq(1, 32'h8001, 4'h6); r.kl = 1; r.ktid = 0; vecs.push_back(r);
        r = seq(2, 32'h43, 4'h7); r.st = 1; r.stid = 0; r.spc = 32'hFFFF_FFFF; vecs.push_back(r);
        vecs.push_back(seq(0, 32'hFFFF_FFFF, 4'h7));
        vecs.push_back(seq(1, 32'h8002, 4'h7));
        vecs.push_back(seq(2, 32'h44, 4'h7));
        vecs.push_back(seq(0, 32'h0, 4'h7));
        // exception and jump on different threads: two flushes in order
        r = seq(0, 32'h1, 4'h7); r.ex = 1; r.etid = 2; r.jm = 1; r.jtid = 1; r.jpc = 32'h90;
        r.fv = 1; r.ft = 2; vecs.push_back(r);
        r = seq(0, 32'h2, 4'h7); r.fv = 1; r.ft = 1; vecs.push_back(r);
        vecs.push_back(seq(1, 32'h90, 4'h7));
        vecs.push_back(seq(2, 32'h8000, 4'h7));
        // jump on an IDLE thread is ignored
        r = seq(0, 32'h3, 4'h7); r.jm = 1; r.jtid = 3; r.jpc = 32'h50; vecs.push_back(r);
        // start on a running thread is ignored
        r = seq(1, 32'h91, 4'h7); r.st = 1; r.stid = 1; r.spc = 32'h500; vecs.push_back(r);
        vecs.push_back(seq(2, 32'h8001, 4'h7));
        vecs.push_back(seq(0, 32'h4, 4'h7));
        vecs.push_back(seq(1, 32'h92, 4'h7));

        // ---- reset ----
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table ----
        foreach (vecs[i]) begin
            r = vecs[i];
            start_en = r.st; start_tid = r.stid; start_pc = r.spc;
            jmp_en   = r.jm; jmp_tid   = r.jtid; jmp_pc   = r.jpc;
            exc_en   = r.ex; exc_tid   = r.etid;
            kill_en  = r.kl; kill_tid  = r.ktid;
            stall    = r.stl;
            step();
            nm = $sformatf("v%0d", i);
            check({nm, "_fetch_valid"}, 32'(fetch_valid), 32'(r.ev));
            if (r.ev) begin
                check({nm, "_fetch_tid"}, 32'(fetch_tid), 32'(r.et));
                check({nm, "_fetch_pc"}, fetch_pc, r.ep);
            end
            check({nm, "_flush_valid"}, 32'(flush_valid), 32'(r.fv));
            if (r.fv) check({nm, "_flush_tid"}, 32'(flush_tid), 32'(r.ft));
            check({nm, "_active"}, 32'(thread_active), 32'(r.act));
        end

        // ---- asynchronous reset mid-stream with a flush pending ----
        clear_inputs();
        exc_en = 1; exc_tid = 1;
        jmp_en = 1; jmp_tid = 2; jmp_pc = 32'h60;
        step();
        check("pre_rst_flush_valid", 32'(flush_valid), 32'd1);
        check("pre_rst_flush_tid", 32'(flush_tid), 32'd1);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_fetch_valid", 32'(fetch_valid), 32'd1);
        check("post_rst_fetch_pc", fetch_pc, 32'h0);
        check("post_rst_fetch_tid", 32'(fetch_tid), 32'd0);
        check("post_rst_pend_dropped", 32'(flush_valid), 32'd0);
        step();
        check("post_rst2_fetch_pc", fetch_pc, 32'h1);
        check("post_rst2_flush_valid", 32'(flush_valid), 32'd0);
        check("post_rst2_active", 32'(thread_active), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
